multiplier_seq_nbit: RTL and testbench
======================================

MULTIPLIER_SEQ_NBIT -- requirements
Module: multiplier_seq_nbit

Interface
REQ-001 Parameter: N, default 6, operand width in bits; legal range N >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request a new multiply; sampled only when accepted (REQ-010).
REQ-005 Port: m  input  N  multiplicand; sampled on the accepting edge only.
REQ-006 Port: q  input  N  multiplier; sampled on the accepting edge only.
REQ-007 Port: is_signed  input  1  1 = operands and result are two's complement, 0 = unsigned; sampled on the accepting edge only.
REQ-008 Port: P  output  2N  registered product; holds its last value until the next completion.
REQ-009 Port: busy  output  1  high while an operation is in progress (state CALC).
REQ-010 Port: done  output  1  one-cycle pulse; P is valid from the same edge.

Function
REQ-011 Radix-2 shift-add FSM with states IDLE, CALC and DONE.
- IDLE -> CALC on start=1.
- CALC -> DONE after N iterations.
- DONE -> CALC if start=1, else DONE -> IDLE.
REQ-012 start shall be accepted only in IDLE or DONE; start in CALC shall be ignored with no effect on operands, count or P.
REQ-013 Accepting edge t0: latch |m| and |q| as N-bit magnitudes (magnitude = raw value when is_signed=0), latch neg = is_signed & (m[N-1] ^ q[N-1]), clear the 2N-bit accumulator, clear the iteration counter, enter CALC.
REQ-014 Each CALC edge shall perform one iteration: if the multiplier LSB = 1, add the shifted multiplicand to the accumulator; shift; increment the counter (width ceil(log2(N))+1).
REQ-015 Latency: iterations occur on edges t0+1 .. t0+N; on edge t0+N, P <= neg ? -acc : acc (2N-bit two's complement), done <= 1, state <= DONE.
REQ-016 done shall be high for exactly the one cycle following edge t0+N, unless a back-to-back start restarts the sequence; busy=0 in IDLE and DONE.
REQ-017 Boundary: m or q = -2^(N-1) signed; the magnitude 2^(N-1) shall be represented exactly in N unsigned bits, and the product shall fit in 2N bits without overflow.
REQ-018 Boundary: an operand equal to 0 shall still take the full N cycles; P = 0, and no negative zero is produced.
REQ-019 Boundary: start held high continuously shall yield one result every N+1 cycles (DONE -> CALC).
REQ-020 P, done and busy shall not change on edges where no transition or completion occurs.

Reset
REQ-021 On an rst=1 edge: state <= IDLE, P <= 0, done <= 0, busy <= 0, accumulator and counter <= 0.
REQ-022 rst shall override start on the same edge.
REQ-023 rst asserted mid-CALC shall abort the operation with no done pulse.

Structure
REQ-024 Shared package mult_pkg shall hold the state encoding constants (IDLE=0, CALC=1, DONE=2, 2 bits) and the reference product function used by benches.
REQ-025 Implementation shall be a single module with no sub-module; the datapath (accumulator, operand shift registers, counter) and the FSM shall reside in multiplier_seq_nbit.
REQ-026 Target size: 120-250 lines of RTL.

Verification
REQ-027 N=6, is_signed=0, m=5, q=7, start for one cycle -> done exactly 6 cycles after the accepting edge, P=35, busy high for 6 cycles.
REQ-028 N=6, is_signed=1, m=6'b100000, q=6'b100000 -> P=1024; m=6'b111111, q=6'b000001 -> P=12'hFFF; m=0, q=6'b100000 -> P=0.
REQ-029 Exhaustive N=6: all 4096 (m,q) pairs for each is_signed value, each result compared against the mult_pkg reference; any mismatch is reported with m, q and P.
REQ-030 start pulsed at CALC iteration 3 with different operands -> ignored; the first result is unchanged and no extra done is produced.
REQ-031 rst asserted at CALC iteration 2 -> next cycle: busy=0, done=0, P=0; a following start then completes normally.
REQ-032 start held high for 3 operations -> done pulses spaced exactly 7 cycles apart, with correct P each time.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding
// and a plain-arithmetic reference product used by benches.
package mult_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Product of two n-bit operands (n <= 31), truncated to 2n bits.
    function automatic logic [63:0] ref_product(
        input int unsigned n,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        sgn
    );
        logic [31:0] w_mask_n;
        logic [63:0] w_mask_2n;
        longint      sa;
        longint      sb;
        longint      prod;
        w_mask_n  = (32'd1 << n) - 32'd1;
        w_mask_2n = (64'd1 << (2 * n)) - 64'd1;
        sa = longint'({32'd0, a & w_mask_n});
        sb = longint'({32'd0, b & w_mask_n});
        if (sgn && a[n-1]) sa = sa - (longint'(1) << n);
        if (sgn && b[n-1]) sb = sb - (longint'(1) << n);
        prod = sa * sb;
        return 64'(prod) & w_mask_2n;
    endfunction

endpackage

// File: rtl/multiplier_seq_nbit.sv
// Radix-2 shift-add multiplier: unsigned magnitudes are multiplied over N
// cycles and the sign is reapplied on the final iteration.
module multiplier_seq_nbit
    import mult_pkg::*;
#(
    parameter int N = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   m,
    input  logic [N-1:0]   q,
    input  logic           is_signed,
    output logic [2*N-1:0] P,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(N) + 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [2*N-1:0]   r_acc;
    logic [2*N-1:0]   r_mcand;
    logic [N-1:0]     r_mplier;
    logic [CW-1:0]    r_count;
    logic             r_neg;
    logic [2*N-1:0]   r_p;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic [N-1:0]     w_m_mag;
    logic [N-1:0]     w_q_mag;
    logic [2*N-1:0]   w_acc_sum;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_CALC) && (r_count == CW'(N - 1));

    // Negating -2^(N-1) wraps to 2^(N-1), which is exact as an unsigned N-bit value.
    assign w_m_mag   = (is_signed && m[N-1]) ? N'(-m) : m;
    assign w_q_mag   = (is_signed && q[N-1]) ? N'(-q) : q;
    assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_CALC;
            S_CALC:  if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_CALC : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
            r_p      <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_mcand  <= {{N{1'b0}}, w_m_mag};
                r_mplier <= w_q_mag;
                r_neg    <= is_signed & (m[N-1] ^ q[N-1]);
                r_acc    <= '0;
                r_count  <= '0;
            end else if (r_state == S_CALC) begin
                r_acc    <= w_acc_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + CW'(1);
                if (w_last) begin
                    r_p    <= r_neg ? -w_acc_sum : w_acc_sum;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign P    = r_p;
    assign done = r_done;
    assign busy = (r_state == S_CALC);

endmodule

// File: tb/tb_multiplier_seq_nbit.sv
// Bench for multiplier_seq_nbit (N=6): cycle model plus scoreboard compare,
// directed boundary cases, exhaustive sweep and a random phase.
module tb_multiplier_seq_nbit;
    import mult_pkg::*;

    localparam int N = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [N-1:0]    tb_m = '0;
    logic [N-1:0]    tb_q = '0;
    logic            tb_s = 1'b0;
    logic [2*N-1:0]  P;
    logic            busy;
    logic            done;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    multiplier_seq_nbit #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .m(tb_m), .q(tb_q),
        .is_signed(tb_s), .P(P), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Model: an accepted request yields its product N edges later.
    int              left = 0;
    logic [2*N-1:0]  pend = '0;
    logic [N-1:0]    pend_m = '0;
    logic [N-1:0]    pend_q = '0;
    logic            pend_s = 1'b0;
    logic [2*N-1:0]  e_p = '0;
    logic            e_done = 1'b0;

    function automatic logic [2*N-1:0] refp(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        logic [63:0] r;
        r = ref_product(N, 32'(a), 32'(b), s);
        return r[2*N-1:0];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            left   <= 0;
            e_done <= 1'b0;
            e_p    <= '0;
        end else if (left > 0) begin
            left   <= left - 1;
            e_done <= (left == 1);
            if (left == 1) e_p <= pend;
        end else begin
            e_done <= 1'b0;
            if (start) begin
                pend   <= refp(tb_m, tb_q, tb_s);
                pend_m <= tb_m;
                pend_q <= tb_q;
                pend_s <= tb_s;
                left   <= N;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (busy !== (left > 0)) begin
                bad++;
                $display("FAIL cyc_busy t=%0t got=%b want=%b", $time, busy, (left > 0));
            end
            total++;
            if (done !== e_done) begin
                bad++;
                $display("FAIL cyc_done t=%0t got=%b want=%b", $time, done, e_done);
            end
            total++;
            if (P !== e_p) begin
                bad++;
                $display("FAIL cyc_P t=%0t m=%0d q=%0d s=%b got=%h want=%h",
                         $time, pend_m, pend_q, pend_s, P, e_p);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                          output logic [2*N-1:0] p, output int cyc, output int bcnt);
        tb_m = a; tb_q = b; tb_s = s; start = 1'b1;
        cyc = 0; bcnt = 0; p = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                p = P;
                break;
            end
            if (cyc > 40) begin
                check("op_timeout", 64'(cyc), 64'd0);
                break;
            end
        end
        $display("op m=%0d q=%0d s=%b P=%h cycles=%0d", a, b, s, p, cyc);
    endtask

    initial begin
        logic [2*N-1:0] p;
        int cyc, bcnt, ndone;
        int dcyc[3];

        // Pin the reference itself to hand-computed values.
        check("ref_u_5x7",    ref_product(6, 32'd5,  32'd7,  1'b0), 64'd35);
        check("ref_s_min2",   ref_product(6, 32'd32, 32'd32, 1'b1), 64'd1024);
        check("ref_s_m1x1",   ref_product(6, 32'd63, 32'd1,  1'b1), 64'hFFF);
        check("ref_s_0xmin",  ref_product(6, 32'd0,  32'd32, 1'b1), 64'd0);
        check("ref_u_63x63",  ref_product(6, 32'd63, 32'd63, 1'b0), 64'd3969);
        check("ref_s_m1xm1",  ref_product(6, 32'd63, 32'd63, 1'b1), 64'd1);

        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("rst_over_start_busy", 64'(busy), 64'd0);
        start = 1'b0;
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_P", 64'(P), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        @(negedge clk);

        run_op(6'd5, 6'd7, 1'b0, p, cyc, bcnt);
        check("u5x7_P", 64'(p), 64'd35);
        check("u5x7_latency", 64'(cyc), 64'(N + 1));
        check("u5x7_busy_cycles", 64'(bcnt), 64'(N));
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("P_holds", 64'(P), 64'd35);

        run_op(6'b100000, 6'b100000, 1'b1, p, cyc, bcnt);
        check("s_min_x_min", 64'(p), 64'd1024);
        run_op(6'b111111, 6'b000001, 1'b1, p, cyc, bcnt);
        check("s_m1_x_1", 64'(p), 64'hFFF);
        run_op(6'd0, 6'b100000, 1'b1, p, cyc, bcnt);
        check("s_0_x_min", 64'(p), 64'd0);
        check("zero_latency", 64'(cyc), 64'(N + 1));

        // Start during CALC is ignored.
        tb_m = 6'd5; tb_q = 6'd7; tb_s = 1'b0; start = 1'b1;
        cyc = 0; ndone = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (cyc == 4) begin tb_m = 6'd63; tb_q = 6'd63; start = 1'b1; end
            if (cyc == 5) start = 1'b0;
            if (done) begin
                ndone++;
                check("ign_P", 64'(P), 64'd35);
                check("ign_cycle", 64'(cyc), 64'(N + 1));
            end
        end
        check("ign_done_count", 64'(ndone), 64'd1);
        $display("op ignored-start dones=%0d", ndone);

        // Reset mid-CALC aborts without a done pulse.
        tb_m = 6'd9; tb_q = 6'd9; tb_s = 1'b0; start = 1'b1;
        cyc = 0;
        while (cyc < 4) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (cyc == 3) rst = 1'b1;
        end
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_P", 64'(P), 64'd0);
        run_op(6'd3, 6'd4, 1'b0, p, cyc, bcnt);
        check("after_abort_P", 64'(p), 64'd12);

        // Start held high: one result every N+1 cycles.
        tb_m = 6'd5; tb_q = 6'd7; tb_s = 1'b0; start = 1'b1;
        cyc = 0; ndone = 0;
        while (ndone < 3 && cyc <= 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin tb_m = 6'd61; tb_q = 6'd4; tb_s = 1'b1; end
            if (cyc == 8) begin tb_m = 6'd63; tb_q = 6'd63; tb_s = 1'b0; end
            if (cyc == 15) start = 1'b0;
            if (done) begin
                dcyc[ndone] = cyc;
                case (ndone)
                    0: check("b2b_P0", 64'(P), 64'd35);
                    1: check("b2b_P1", 64'(P), 64'hFF4);
                    default: check("b2b_P2", 64'(P), 64'd3969);
                endcase
                ndone++;
            end
        end
        start = 1'b0;
        check("b2b_count", 64'(ndone), 64'd3);
        if (ndone == 3) begin
            check("b2b_first", 64'(dcyc[0]), 64'(N + 1));
            check("b2b_gap1", 64'(dcyc[1] - dcyc[0]), 64'(N + 1));
            check("b2b_gap2", 64'(dcyc[2] - dcyc[1]), 64'(N + 1));
        end
        $display("op back-to-back dones=%0d", ndone);
        repeat (3) @(negedge clk);

        // Exhaustive sweep, start held high; the per-cycle compare checks each P.
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 64; a++) begin
                for (int b = 0; b < 64; b++) begin
                    tb_m = 6'(a); tb_q = 6'(b); tb_s = s[0]; start = 1'b1;
                    repeat (N + 1) @(negedge clk);
                end
            end
            $display("op exhaustive is_signed=%0d swept", s);
        end
        start = 1'b0;
        repeat (N + 3) @(negedge clk);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 3) == 0);
            tb_m  = 6'($urandom);
            tb_q  = 6'($urandom);
            tb_s  = 1'($urandom);
            rst   = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        rst = 1'b0;
        repeat (N + 3) @(negedge clk);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
